planificador_serial: RTL and testbench



---
 rtl/planificador_serial_pkg.sv | 15 +
 rtl/planificador_serial_rr_selector.sv | 44 ++++
 rtl/planificador_serial.sv | 162 ++++++++++++++++
 tb/tb_planificador_serial.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/planificador_serial_pkg.sv
// Shared definitions for the planificador_serial byte scheduler:
// FSM state encoding, line symbols and the grant_id width.
package planificador_pkg;

  localparam int          GRANT_W    = 4;
  localparam logic [7:0]  K_COMMA    = 8'hBC;
  localparam logic [3:0]  TAG_PREFIX = 4'hF;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SYNC,
    ST_ACTIVE
  } state_e;

endpackage

// File: rtl/planificador_serial_rr_selector.sv
// rr_selector: combinational round-robin picker. Keeps the current holder
// while its burst lasts, otherwise scans ptr+1, ptr+2, ... modulo N_REQ.
// The scan reaches ptr itself last, so a lone holder whose burst expired is
// picked again.
module rr_selector
  import planificador_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  input  logic [GRANT_W-1:0] holder,
  input  logic               holder_valid,
  input  logic               burst_expired,
  output logic [GRANT_W-1:0] sel,
  output logic               sel_valid
);

  logic [N_REQ-1:0] req_sh;
  int               idx;

  // Holder-first selection, then wrap-around scan starting after the pointer.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel       = '0;
    sel_valid = 1'b0;
    idx       = 0;
    req_sh    = req >> holder;
    if (holder_valid && !burst_expired && req_sh[0]) begin
      sel       = holder;
      sel_valid = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx    = (int'(ptr) + k) % N_REQ;
        req_sh = req >> idx;
        if (!sel_valid && req_sh[0]) begin
          sel       = GRANT_W'(idx);
          sel_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/planificador_serial.sv
// planificador_serial: shares one paralelo_serial lane among N_REQ byte
// sources. OFF -> SYNC (SYNC_LEN idle cycles, line shows the comma) ->
// ACTIVE (round-robin with a BURST_MAX burst limit).
// Optional: define CHANNEL_TAG_EN to insert a {F, id} tag byte before the
// first byte of every new requester run.
module planificador_serial
  import planificador_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SYNC_LEN  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic                 enable_link,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 valid_out,
  output logic [7:0]           data_out,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 link_active
);

  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0]      SYNC_LAST = SW'(SYNC_LEN - 1);
  localparam logic [BW-1:0]      BURST_LIM = BW'(BURST_MAX);
  localparam logic [GRANT_W-1:0] PTR_RST   = GRANT_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [SW-1:0]      sync_q, sync_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic [7:0]         data_q, data_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic               link_q, link_d;
`ifdef CHANNEL_TAG_EN
  logic               first_q, first_d;
`endif

  logic [GRANT_W-1:0] sel;
  logic               sel_valid;
  logic               holder_valid;
  logic               burst_expired;
  logic [8*N_REQ-1:0] data_sh;

  // The holder is the last requester that transferred; it exists only while
  // a burst is running (burst_q != 0).
  assign holder_valid  = (burst_q != '0);
  assign burst_expired = (burst_q >= BURST_LIM);
  assign data_sh       = req_data >> {sel, 3'b000};

  rr_selector #(.N_REQ(N_REQ)) u_sel (
    .req           (req_valid),
    .ptr           (ptr_q),
    .holder        (ptr_q),
    .holder_valid  (holder_valid),
    .burst_expired (burst_expired),
    .sel           (sel),
    .sel_valid     (sel_valid)
  );

  // Next-state, ready and output computation for the link FSM.
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    burst_d   = burst_q;
    ptr_d     = ptr_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    grant_d   = grant_q;
    req_ready = '0;
`ifdef CHANNEL_TAG_EN
    first_d   = first_q;
`endif
    if (!enable_link) begin
      state_d = ST_OFF;
      sync_d  = '0;
      burst_d = '0;
      ptr_d   = PTR_RST;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_SYNC;
          sync_d  = '0;
        end
        ST_SYNC: begin
          if (sync_q == SYNC_LAST) begin
            state_d = ST_ACTIVE;
            sync_d  = '0;
          end else begin
            sync_d = sync_q + SW'(1);
          end
        end
        ST_ACTIVE: begin
          if (!sel_valid) begin
            burst_d = '0;
`ifdef CHANNEL_TAG_EN
          end else if (first_q || (sel != grant_q)) begin
            // Tag cycle: nothing accepted, burst and pointer untouched.
            valid_d = 1'b1;
            data_d  = {TAG_PREFIX, sel};
            grant_d = sel;
            first_d = 1'b0;
`endif
          end else begin
            req_ready = N_REQ'(1) << sel;
            valid_d   = 1'b1;
            data_d    = data_sh[7:0];
            grant_d   = sel;
            ptr_d     = sel;
            burst_d   = (holder_valid && (sel == ptr_q) && !burst_expired)
                        ? burst_q + BW'(1) : BW'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
`ifdef CHANNEL_TAG_EN
    if (state_q != ST_ACTIVE) first_d = 1'b1;
`endif
    link_d = (state_d == ST_ACTIVE);
  end

  // State and registered outputs, asynchronously cleared by reset.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      sync_q  <= '0;
      burst_q <= '0;
      ptr_q   <= PTR_RST;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      grant_q <= '0;
      link_q  <= 1'b0;
`ifdef CHANNEL_TAG_EN
      first_q <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      sync_q  <= sync_d;
      burst_q <= burst_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      link_q  <= link_d;
`ifdef CHANNEL_TAG_EN
      first_q <= first_d;
`endif
    end
  end

  assign valid_out   = valid_q;
  assign data_out    = data_q;
  assign grant_id    = grant_q;
  assign link_active = link_q;

endmodule

// File: tb/tb_planificador_serial.sv
// Directed bench for planificador_serial (N_REQ=4, SYNC_LEN=8, BURST_MAX=2).
// Requester i presents byte 16*i+1 unless a test overrides it.
module tb_planificador_serial;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic        enable_link;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        valid_out;
  logic [7:0]  data_out;
  logic [3:0]  grant_id;
  logic        link_active;

  int checks = 0;
  int errors = 0;

  planificador_serial #(.N_REQ(4), .SYNC_LEN(8), .BURST_MAX(2)) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .enable_link (enable_link),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .grant_id    (grant_id),
    .link_active (link_active)
  );

  always #5 clk_4f = ~clk_4f;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic set_default_data();
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'(16*i + 1);
  endtask

  task automatic do_reset();
    enable_link = 1'b0;
    req_valid   = '0;
    set_default_data();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic bring_up();
    enable_link = 1'b1;
    repeat (9) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_link = 1'b1; req_valid = 4'hF; set_default_data();
    #3;
    repeat (2) begin
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
      checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
      checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL reset_link got=%b exp=0", link_active); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      tick();
    end
    enable_link = 1'b0; req_valid = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bring_up();
    do_reset();
    req_valid = 4'hF;
    enable_link = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL sync_valid cycle=%0d got=%b exp=0", c, valid_out); end
      checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL sync_link cycle=%0d got=%b exp=0", c, link_active); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL sync_ready cycle=%0d got=%b exp=0000", c, req_ready); end
    end
    tick();
    checks++; if (link_active !== 1'b1) begin errors++; $display("FAIL active_link cycle=9 got=%b exp=1", link_active); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL active_valid cycle=9 got=%b exp=0", valid_out); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL active_ready cycle=9 got=%b exp=0001", req_ready); end
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL first_valid cycle=10 got=%b exp=1", valid_out); end
    checks++; if (grant_id !== 4'd0) begin errors++; $display("FAIL first_grant cycle=10 got=%0d exp=0", grant_id); end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL first_data cycle=10 got=%h exp=01", data_out); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [9] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0};
    do_reset();
    req_valid = 4'hF;
    bring_up();
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rr_valid beat=%0d got=%b exp=1", k, valid_out); end
      checks++; if (grant_id !== exp_g[k]) begin errors++; $display("FAIL rr_grant beat=%0d got=%0d exp=%0d", k, grant_id, exp_g[k]); end
      checks++; if (data_out !== 8'(16*exp_g[k] + 1)) begin errors++; $display("FAIL rr_data beat=%0d got=%h exp=%h", k, data_out, 8'(16*exp_g[k] + 1)); end
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    req_valid = 4'b0100;
    bring_up();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL solo_valid beat=%0d got=%b exp=1", k, valid_out); end
      checks++; if (grant_id !== 4'd2) begin errors++; $display("FAIL solo_grant beat=%0d got=%0d exp=2", k, grant_id); end
      checks++; if (data_out !== 8'h21) begin errors++; $display("FAIL solo_data beat=%0d got=%h exp=21", k, data_out); end
    end
  endtask

  task automatic test_drop_and_switch();
    req_valid = 4'b0010;
    tick();
    checks++; if (valid_out !== 1'b1 || grant_id !== 4'd1 || data_out !== 8'h11) begin
      errors++; $display("FAIL drop_first got=%b/%0d/%h exp=1/1/11", valid_out, grant_id, data_out); end
    req_valid = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle_valid cycle=%0d got=%b exp=0", k, valid_out); end
      checks++; if (grant_id !== 4'd1 || data_out !== 8'h11) begin
        errors++; $display("FAIL idle_hold cycle=%0d got=%0d/%h exp=1/11", k, grant_id, data_out); end
    end
    req_data[31:24] = 8'hBC;
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL switch_ready got=%b exp=1000", req_ready); end
    tick();
    checks++; if (valid_out !== 1'b1 || grant_id !== 4'd3) begin
      errors++; $display("FAIL switch_grant got=%b/%0d exp=1/3", valid_out, grant_id); end
    checks++; if (data_out !== 8'hBC) begin errors++; $display("FAIL comma_pass got=%h exp=bc", data_out); end
  endtask

  task automatic test_disable_mid_burst();
    do_reset();
    req_valid = 4'b0100;
    bring_up();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL dis_pre_ready got=%b exp=0100", req_ready); end
    tick();
    checks++; if (valid_out !== 1'b1 || grant_id !== 4'd2) begin
      errors++; $display("FAIL dis_first got=%b/%0d exp=1/2", valid_out, grant_id); end
    enable_link = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL dis_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL dis_valid got=%b exp=0", valid_out); end
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL dis_link got=%b exp=0", link_active); end
    req_valid = 4'hF;
    enable_link = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (valid_out !== 1'b0 || link_active !== 1'b0) begin
        errors++; $display("FAIL resync cycle=%0d got=%b/%b exp=0/0", c, valid_out, link_active); end
    end
    tick();
    checks++; if (link_active !== 1'b1) begin errors++; $display("FAIL resync_link got=%b exp=1", link_active); end
    tick();
    checks++; if (valid_out !== 1'b1 || grant_id !== 4'd0) begin
      errors++; $display("FAIL resync_grant got=%b/%0d exp=1/0", valid_out, grant_id); end
  endtask

  task automatic test_tag();
    logic [7:0] exp_d [7] = '{8'hF0, 8'h01, 8'h01, 8'hF1, 8'h11, 8'h11, 8'hF0};
    logic [3:0] exp_r [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    logic [3:0] exp_g [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
    do_reset();
    req_valid = 4'b0011;
    bring_up();
    for (int k = 0; k < 7; k++) begin
      checks++; if (req_ready !== exp_r[k]) begin errors++; $display("FAIL tag_ready beat=%0d got=%b exp=%b", k, req_ready, exp_r[k]); end
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL tag_valid beat=%0d got=%b exp=1", k, valid_out); end
      checks++; if (data_out !== exp_d[k]) begin errors++; $display("FAIL tag_data beat=%0d got=%h exp=%h", k, data_out, exp_d[k]); end
      checks++; if (grant_id !== exp_g[k]) begin errors++; $display("FAIL tag_grant beat=%0d got=%0d exp=%0d", k, grant_id, exp_g[k]); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable_link = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    test_reset();
`ifdef CHANNEL_TAG_EN
    test_tag();
`else
    test_bring_up();
    test_round_robin();
    test_single_requester();
    test_drop_and_switch();
    test_disable_mid_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
